// File: rtl/dclkfifo_wr_arbiter.sv
// Round-robin packet arbiter sharing one dual-clock FIFO write port among NREQ requesters.
// Optional DCLKFIFO_ARB_SPACE_CHECK_EN: defer grants until the FIFO can absorb a maximum-length packet.
module dclkfifo_wr_arbiter #(
    parameter int unsigned NREQ            = 4,
    parameter int unsigned FIFO_WIDTH      = 8,
    parameter int unsigned LOG2_FIFO_DEPTH = 3,
    parameter int unsigned MAX_PKT_LEN     = 4
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ-1:0]              req_last,
    input  logic [NREQ*FIFO_WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]              req_ready,
    output logic                         fifo_wen,
    output logic [FIFO_WIDTH-1:0]        fifo_wdata,
    input  logic                         fifo_wfull,
    input  logic [LOG2_FIFO_DEPTH:0]     fifo_wlevel,
    output logic [NREQ-1:0]              grant,
    output logic                         busy,
    output logic                         pkt_err
);

    localparam int unsigned IDXW  = $clog2(NREQ);
    localparam int unsigned CNTW  = $clog2(MAX_PKT_LEN + 1);
    localparam int unsigned LVLW  = LOG2_FIFO_DEPTH + 1;
    localparam int unsigned SPW   = LVLW + 1;
    localparam int unsigned DEPTH = 2 ** LOG2_FIFO_DEPTH;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0] win_idx;
    logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            busy_q, busy_d;
    logic            pkt_err_q, pkt_err_d;
    logic            win_found;
    logic            space_ok;
    logic            beat_acc;
    logic            beat_last;
    logic            pkt_done;
    logic            wdog_hit;
    int unsigned     cand;

`ifdef DCLKFIFO_ARB_SPACE_CHECK_EN
    // Only start a packet when a full-length packet fits in the remaining FIFO space.
    logic [SPW-1:0] free_slots;
    assign free_slots = SPW'(DEPTH) - SPW'(fifo_wlevel);
    assign space_ok   = (SPW'(fifo_wlevel) <= SPW'(DEPTH)) && (free_slots >= SPW'(MAX_PKT_LEN));
`else
    logic unused_wlevel;
    assign unused_wlevel = ^fifo_wlevel;
    assign space_ok      = 1'b1;
`endif

    // Round-robin search: first valid requester after the last owner, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        cand      = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!win_found && req_valid[IDXW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDXW'(cand);
            end
        end
    end

    // Output comb: owner handshake and write-port mux (zero latency).
    always_comb begin
        req_ready  = '0;
        fifo_wdata = '0;
        fifo_wen   = 1'b0;
        beat_last  = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready[i] = grant_q[i] & ~fifo_wfull;
            if (grant_q[i]) begin
                fifo_wdata = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
                beat_last  = req_last[i];
            end
        end
        fifo_wen = |(req_valid & req_ready);
    end

    assign beat_acc = fifo_wen;
    assign cnt_inc  = cnt_q + CNTW'(1);
    assign pkt_done = beat_acc & beat_last;
    assign wdog_hit = beat_acc & ~beat_last & (cnt_inc == CNTW'(MAX_PKT_LEN));

    // Next-state comb.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        pkt_err_d = 1'b0;
        busy_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found && space_ok) begin
                    state_d = ST_GRANT;
                    owner_d = win_idx;
                    grant_d = NREQ'(1) << win_idx;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (beat_acc) begin
                    cnt_d = cnt_inc;
                end
                // Last beat or watchdog both hand the port back; owner drops to lowest priority.
                if (pkt_done || wdog_hit) begin
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    rr_ptr_d  = owner_q;
                    cnt_d     = '0;
                    pkt_err_d = wdog_hit;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_GRANT);
    end

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered grant/owner/pointer/counter/status.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            grant_q   <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= IDXW'(NREQ - 1);
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            pkt_err_q <= 1'b0;
        end else begin
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            pkt_err_q <= pkt_err_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign pkt_err = pkt_err_q;

endmodule
